// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART types, FSM states and the baud divider constant
package uart_rx_pkg;
  localparam int CPU_CLK_HZ = 100_000_000;
  localparam int UART_BAUD = 115_200;
  localparam int UART_CLKS_PER_BIT = CPU_CLK_HZ / UART_BAUD;
  typedef logic [7:0] uart_data_t;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} uart_rx_state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser for the async rx pin, resets to idle-high
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic s1;
  // two-stage metastability filter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, s1} <= 2'b11;
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with valid/ready holding register; UART_RX_PARITY_EN adds even parity
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,output logic                parity_err
`endif
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  uart_rx_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic rx_s, last, half, stop_hit, good, deliver, par_bad;
  uart_rx_sync u_sync (.clk(clk), .rst_n(rst_n), .d(rx), .q(rx_s));
  assign last = cnt == LAST;
  assign half = cnt == HALF;
  assign busy = state != IDLE;
  // next state plus the stop-bit decision strobes
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = rx_s ? IDLE : START;
      START:   state_n = half ? (rx_s ? IDLE : DATA) : START;
`ifdef UART_RX_PARITY_EN
      DATA:    state_n = (last && bit_cnt == BW'(DATA_BITS - 1)) ? PARITY : DATA;
`else
      DATA:    state_n = (last && bit_cnt == BW'(DATA_BITS - 1)) ? STOP : DATA;
`endif
      PARITY:  state_n = last ? STOP : PARITY;
      STOP:    state_n = last ? (rx_s ? IDLE : BREAK) : STOP;
      BREAK:   state_n = rx_s ? IDLE : BREAK;
      default: state_n = IDLE;
    endcase
    stop_hit = state == STOP && last;
    good = stop_hit && rx_s && !par_bad;
    deliver = good && (!rx_valid || rx_ready);
  end
`ifdef UART_RX_PARITY_EN
  // latch parity mismatch at the parity mid-bit; report alongside the stop sample
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      par_bad <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad <= (state == PARITY && last) ? rx_s ^ (^shreg) : (state == START ? 1'b0 : par_bad);
      parity_err <= stop_hit && par_bad;
    end
`else
  assign par_bad = 1'b0;
`endif
  // FSM state, bit timing, shift register, holding register and flag pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (state == IDLE || state_n != state || last) ? '0 : cnt + 1'b1;
      bit_cnt <= state == START ? '0 : (state == DATA && last) ? bit_cnt + 1'b1 : bit_cnt;
      if (state == DATA && last) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (deliver) rx_data <= shreg;
      rx_valid <= deliver || (rx_valid && !rx_ready);
      frame_err <= stop_hit && (!rx_s || par_bad);
      overrun <= good && rx_valid && !rx_ready;
    end
endmodule
